// File: rtl/spad_loader_pkg.sv
// Shared types and defaults for the PE scratchpad loader.
// State encoding plus the default scratchpad geometry.
package spad_loader_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int SPAD_DEPTH_DEF = 12;
    localparam int ADDR_WIDTH_DEF = $clog2(SPAD_DEPTH_DEF);
    localparam int CNT_WIDTH_DEF  = $clog2(SPAD_DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spad_loader_if.sv
// FIFO read port and scratchpad write port seen by the loader.
// The master side pops the FIFO and drives the scratchpad write.
interface spad_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  fifo_read_en;
    logic                  spad_write_en;
    logic [ADDR_WIDTH-1:0] spad_write_addr;
    logic [DATA_WIDTH-1:0] spad_write_data;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        output fifo_read_en,
        output spad_write_en,
        output spad_write_addr,
        output spad_write_data
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        input  fifo_read_en,
        input  spad_write_en,
        input  spad_write_addr,
        input  spad_write_data
    );
endinterface

// File: rtl/spad_loader.sv
// Drains a FWFT FIFO into a PE scratchpad: len words from base_addr, wrapping.
// Latency: pop to spad write is 1 cycle; done pulses the cycle after the final write.
// Backpressure: empty FIFO or hold stalls pops; abort squashes and returns to idle.
module spad_loader
    import spad_loader_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int SPAD_DEPTH = SPAD_DEPTH_DEF,
    localparam int ADDR_WIDTH = $clog2(SPAD_DEPTH),
    localparam int CNT_WIDTH  = $clog2(SPAD_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 hold,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    spad_loader_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] zero_cnt
);

    localparam logic [CNT_WIDTH-1:0]  DEPTH_C   = CNT_WIDTH'(SPAD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SPAD_DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]  remaining;
    logic [CNT_WIDTH-1:0]  len_eff;
    logic [ADDR_WIDTH-1:0] base_eff;
    logic [31:0]           base_wide;
    logic                  pop;

    // Out-of-range lengths and base addresses are folded back into the scratchpad.
    assign len_eff   = (len > DEPTH_C) ? DEPTH_C : len;
    assign base_wide = {{(32 - ADDR_WIDTH){1'b0}}, base_addr};
    assign base_eff  = ADDR_WIDTH'(base_wide % 32'(SPAD_DEPTH));

    assign bus.fifo_read_en = (state == ST_LOAD) && (remaining != '0) && !hold && !abort;
    assign pop              = bus.fifo_read_en && !bus.fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            addr                <= '0;
            remaining           <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            zero_cnt            <= '0;
            bus.spad_write_en   <= 1'b0;
            bus.spad_write_addr <= '0;
            bus.spad_write_data <= '0;
        end else begin
            bus.spad_write_en <= 1'b0;
            done              <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= base_eff;
                        remaining <= len_eff;
                        zero_cnt  <= '0;
                        if (len_eff == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                    end else if (pop) begin
                        bus.spad_write_en   <= 1'b1;
                        bus.spad_write_addr <= addr;
                        bus.spad_write_data <= bus.fifo_read_data;
                        addr      <= (addr == LAST_ADDR) ? '0 : addr + ADDR_WIDTH'(1);
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (bus.fifo_read_data == '0 && zero_cnt != DEPTH_C)
                            zero_cnt <= zero_cnt + CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The last word's write is on the bus this cycle.
                    busy <= 1'b0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spad_loader.sv
// Scoreboard bench for spad_loader: FIFO model in a queue, expected writes queued at launch.
module tb_spad_loader;
    import spad_loader_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int CW    = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          hold;
    logic [CW-1:0] len;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic [CW-1:0] zero_cnt;

    spad_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    spad_loader #(.DATA_WIDTH(DW), .SPAD_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .len       (len),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .zero_cnt  (zero_cnt)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] fifo_q[$];
    wr_t           exp_q[$];
    bit            starve = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty     = starve || (fifo_q.size() == 0);
        bus.fifo_read_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    // FWFT FIFO: the head word leaves on any accepted pop.
    always @(posedge clk) begin
        if (bus.fifo_read_en && !bus.fifo_empty)
            void'(fifo_q.pop_front());
    end

    task automatic run_load(input string nm, input int ln, input int base, input int starve_cyc,
                            input int hold_after, input int hold_len, input int abort_at,
                            input bit start_abort,
                            output int first_pop, output int last_pop,
                            output int first_wr, output int done_cyc);
        logic [DW-1:0] words[$];
        wr_t e;
        int  nwords, len_eff, base_eff, n_exp, zeros, pops;
        int  wr_cnt, done_cnt, hold_left, tail;
        bit  aborted, abort_chk, hold_done, finished;
        words    = fifo_q;
        nwords   = words.size();
        len_eff  = (ln > DEPTH) ? DEPTH : ln;
        base_eff = base % DEPTH;
        n_exp    = (abort_at > 0 && abort_at - 1 < len_eff) ? abort_at - 1 : len_eff;
        zeros    = 0;
        for (int i = 0; i < n_exp; i++) begin
            exp_q.push_back(wr_t'{addr: AW'((base_eff + i) % DEPTH), data: words[i]});
            if (words[i] == '0) zeros++;
        end
        first_pop = 0; last_pop = 0; first_wr = 0; done_cyc = 0;
        wr_cnt = 0; done_cnt = 0; hold_left = 0; tail = 0;
        aborted = 0; abort_chk = 0; hold_done = 0; finished = 0;

        @(negedge clk);
        start     = 1'b1;
        len       = CW'(ln);
        base_addr = AW'(base);
        abort     = start_abort;
        starve    = (starve_cyc > 0);
        drive_fifo();

        for (int k = 1; k <= 80 && !finished; k++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            hold  = 1'b0;
            if (bus.spad_write_en) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = k;
                if (exp_q.size() == 0) begin
                    chk({nm, " extra_write"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk({nm, " wr_addr"}, bus.spad_write_addr, e.addr);
                    chk({nm, " wr_data"}, bus.spad_write_data, e.data);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (aborted && !abort_chk) begin
                chk({nm, " busy_after_abort"}, busy, 0);
                abort_chk = 1;
            end
            if (k > 1 && !busy && !done && (done_cnt > 0 || aborted)) tail++;
            if (tail == 3) finished = 1;

            pops = nwords - fifo_q.size();
            if (k > starve_cyc) starve = 1'b0;
            if (hold_left > 0) begin
                hold = 1'b1;
                hold_left--;
            end else if (hold_after > 0 && pops == hold_after && !hold_done) begin
                hold      = 1'b1;
                hold_left = hold_len - 1;
                hold_done = 1;
            end
            if (abort_at > 0 && !aborted && pops == abort_at - 1) begin
                abort   = 1'b1;
                aborted = 1;
            end
            // A start request mid-load must not disturb the run.
            if (k == 2 && len_eff >= 3 && abort_at == 0) begin
                start     = 1'b1;
                len       = CW'(3);
                base_addr = AW'(5);
            end
            drive_fifo();
            #1;
            if (abort) chk({nm, " ren_on_abort"}, bus.fifo_read_en, 0);
            if (hold)  chk({nm, " ren_on_hold"}, bus.fifo_read_en, 0);
            if (bus.fifo_read_en && !bus.fifo_empty) begin
                if (first_pop == 0) first_pop = k;
                last_pop = k;
            end
        end

        if (!finished) chk({nm, " timeout"}, 0, 1);
        chk({nm, " writes"}, wr_cnt, n_exp);
        chk({nm, " pops"}, nwords - fifo_q.size(), n_exp);
        chk({nm, " done_pulses"}, done_cnt, aborted ? 0 : 1);
        chk({nm, " exp_left"}, exp_q.size(), 0);
        chk({nm, " zero_cnt"}, zero_cnt, zeros);
        exp_q.delete();
        fifo_q.delete();
        starve = 1'b0;
        drive_fifo();
    endtask

    int fp, lp, fw, dc;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
        len = '0; base_addr = '0;
        drive_fifo();
        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst wr_en", bus.spad_write_en, 0);
        chk("rst wr_addr", bus.spad_write_addr, 0);
        chk("rst wr_data", bus.spad_write_data, 0);
        chk("rst zero_cnt", zero_cnt, 0);
        chk("rst ren", bus.fifo_read_en, 0);
        rst = 1'b0;

        // Basic run: cycle-exact pop, write and done timing.
        for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
        run_load("t1", 4, 0, 0, 0, 0, 0, 1'b0, fp, lp, fw, dc);
        chk("t1 first_pop", fp, 1);
        chk("t1 last_pop", lp, 4);
        chk("t1 first_wr", fw, 2);
        chk("t1 done_cyc", dc, 6);

        // Wrap past the top of the scratchpad; abort alongside start in IDLE loses.
        for (int i = 0; i < 7; i++) fifo_q.push_back(DW'(16'h100 + i));
        run_load("t2", 5, 10, 0, 0, 0, 0, 1'b1, fp, lp, fw, dc);
        chk("t2 done_cyc", dc, 7);

        // Starved FIFO, zero counting.
        fifo_q.push_back(16'd0); fifo_q.push_back(16'd7); fifo_q.push_back(16'd0);
        run_load("t3", 3, 2, 3, 0, 0, 0, 1'b0, fp, lp, fw, dc);
        chk("t3 first_pop", fp, 4);

        // Hold after the second pop for two cycles.
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(16'hA0 + i));
        run_load("t4", 4, 3, 0, 2, 2, 0, 1'b0, fp, lp, fw, dc);
        chk("t4 last_pop", lp, 6);

        // Abort on the cycle of the third pop.
        for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(16'h50 + i));
        run_load("t5", 6, 1, 0, 0, 0, 3, 1'b0, fp, lp, fw, dc);

        // Zero length: straight to done.
        fifo_q.push_back(16'h1234); fifo_q.push_back(16'h5678);
        run_load("t6a", 0, 4, 0, 0, 0, 0, 1'b0, fp, lp, fw, dc);
        chk("t6a early_done", (dc >= 1 && dc <= 2), 1);

        // Oversized length clamps to the scratchpad depth; extra FIFO words stay.
        for (int i = 0; i < 15; i++) fifo_q.push_back((i % 4 == 0) ? 16'd0 : DW'(i));
        run_load("t6b", 15, 0, 0, 0, 0, 0, 1'b0, fp, lp, fw, dc);

        // Base address beyond the depth folds back modulo the depth.
        for (int i = 0; i < 3; i++) fifo_q.push_back(DW'(16'hC0 + i));
        run_load("t7", 3, 14, 0, 0, 0, 0, 1'b0, fp, lp, fw, dc);

        // Reset in the middle of a load.
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(i + 1));
        @(negedge clk);
        start = 1'b1; len = CW'(8); base_addr = '0;
        drive_fifo();
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            drive_fifo();
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst wr_en", bus.spad_write_en, 0);
        chk("mid_rst busy", busy, 0);
        chk("mid_rst done", done, 0);
        chk("mid_rst ren", bus.fifo_read_en, 0);
        rst = 1'b0;
        fifo_q.delete();
        drive_fifo();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
